// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan driver: the hex glyph table,
// the blank pattern and the digit-index width helper.
package seg7_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h00;

   // Glyphs are {g,f,e,d,c,b,a} with logical 1 meaning the segment is lit.
   function automatic logic [6:0] seg7_hex(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0: s = 7'h3F;
         4'h1: s = 7'h06;
         4'h2: s = 7'h5B;
         4'h3: s = 7'h4F;
         4'h4: s = 7'h66;
         4'h5: s = 7'h6D;
         4'h6: s = 7'h7D;
         4'h7: s = 7'h07;
         4'h8: s = 7'h7F;
         4'h9: s = 7'h6F;
         4'hA: s = 7'h77;
         4'hB: s = 7'h7C;
         4'hC: s = 7'h39;
         4'hD: s = 7'h5E;
         4'hE: s = 7'h79;
         default: s = 7'h71;
      endcase
      return s;
   endfunction

   // A one-digit display still gets a 1-bit index so the counter never collapses to zero width.
   function automatic int idx_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/display7seg_scan_if.sv
// Bundle between the register side (value/load) and the display pins of
// the scan driver; the driver takes the slave view.
interface display7seg_scan_if #(
   parameter int N_DIGITS = 4
);
   logic                  load;
   logic [4*N_DIGITS-1:0] value;
   logic [N_DIGITS-1:0]   dp_in;
   logic                  blank_lz;
   logic [6:0]            seg;
   logic                  dp;
   logic [N_DIGITS-1:0]   an;
   logic                  frame_done;

   modport master (
      output load, value, dp_in, blank_lz,
      input  seg, dp, an, frame_done
   );

   modport slave (
      input  load, value, dp_in, blank_lz,
      output seg, dp, an, frame_done
   );
endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational nibble-to-glyph decoder used on the currently scanned digit.
module seg7_hex_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nib,
   output logic [6:0] seg
);

   assign seg = seg7_hex(nib);

endmodule

// File: rtl/display7seg_scan.sv
// Time-multiplexed N-digit 7-segment driver with frame-aligned (tear-free)
// value updates and optional leading-zero blanking.
module display7seg_scan
   import seg7_pkg::*;
#(
   parameter int N_DIGITS       = 4,
   parameter int SCAN_DIV       = 50000,
   parameter int SEG_ACTIVE_LOW = 0,
   parameter int AN_ACTIVE_LOW  = 0
) (
   input logic               clk,
   input logic               rst_n,
   display7seg_scan_if.slave bus
);

   localparam int IDX_W = idx_w(N_DIGITS);
   localparam int PW    = (SCAN_DIV < 2) ? 1 : $clog2(SCAN_DIV);

   localparam logic [PW-1:0]    PRESC_LAST = PW'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIGITS - 1);

   localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
   localparam logic AN_INV  = (AN_ACTIVE_LOW != 0);

   localparam logic [6:0]          SEG_OFF = {7{SEG_INV}};
   localparam logic [N_DIGITS-1:0] AN_OFF  = {N_DIGITS{AN_INV}};

   if (N_DIGITS < 1 || N_DIGITS > 8 || SCAN_DIV < 1) begin : g_bad_params
      $error("display7seg_scan: illegal parameters N_DIGITS=%0d SCAN_DIV=%0d", N_DIGITS, SCAN_DIV);
   end

   logic [PW-1:0]         presc;
   logic [IDX_W-1:0]      idx;
   logic                  tc;
   logic                  wrap;

   logic [4*N_DIGITS-1:0] pendValue;
   logic [N_DIGITS-1:0]   pendDp;
   logic                  pendVld;
   logic [4*N_DIGITS-1:0] actValue;
   logic [N_DIGITS-1:0]   actDp;

   logic [3:0]            curNib;
   logic                  curDp;
   logic                  curLeadZero;
   logic                  leadZero;
   logic [N_DIGITS-1:0]   anNext;
   logic [6:0]            segLogic;
   logic [6:0]            segNext;

   assign tc   = (presc == PRESC_LAST);
   assign wrap = tc && (idx == IDX_LAST);

   // Slot timing: the prescaler sets the dwell per digit, idx walks the digits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc <= '0;
         idx   <= '0;
      end else if (tc) begin
         presc <= '0;
         idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
         presc <= presc + 1'b1;
      end
   end

   // Double-buffered content: loads land in pending, and only the frame wrap
   // copies into active, so a frame never mixes old and new digits. A load on
   // the wrap cycle itself bypasses pending so it is not delayed a whole frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pendValue <= '0;
         pendDp    <= '0;
         pendVld   <= 1'b0;
         actValue  <= '0;
         actDp     <= '0;
      end else begin
         if (bus.load) begin
            pendValue <= bus.value;
            pendDp    <= bus.dp_in;
            pendVld   <= 1'b1;
         end
         if (wrap) begin
            if (bus.load) begin
               actValue <= bus.value;
               actDp    <= bus.dp_in;
            end else if (pendVld) begin
               actValue <= pendValue;
               actDp    <= pendDp;
            end
            pendVld <= 1'b0;
         end
      end
   end

   // Walk from the most significant digit down so leadZero says whether this
   // digit and everything above it is zero when we reach the scanned one.
   always_comb begin
      curNib      = 4'h0;
      curDp       = 1'b0;
      curLeadZero = 1'b0;
      leadZero    = 1'b1;
      anNext      = '0;
      for (int k = N_DIGITS - 1; k >= 0; k--) begin
         leadZero = leadZero && (actValue[4*k +: 4] == 4'h0);
         if (idx == IDX_W'(k)) begin
            curNib      = actValue[4*k +: 4];
            curDp       = actDp[k];
            curLeadZero = leadZero && (k > 0);
            anNext[k]   = 1'b1;
         end
      end
   end

   seg7_hex_decode u_decode (
      .nib (curNib),
      .seg (segLogic)
   );

   assign segNext = (bus.blank_lz && curLeadZero) ? SEG_BLANK : segLogic;

   // Pin registers: polarity is applied only here, and reset parks every pin
   // at its inactive level so the display is dark while held in reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.seg        <= SEG_OFF;
         bus.dp         <= SEG_INV;
         bus.an         <= AN_OFF;
         bus.frame_done <= 1'b0;
      end else begin
         bus.seg        <= segNext ^ SEG_OFF;
         bus.dp         <= curDp ^ SEG_INV;
         bus.an         <= anNext ^ AN_OFF;
         bus.frame_done <= wrap;
      end
   end

endmodule

// File: tb/tb_display7seg_scan.sv
// Bench for display7seg_scan: an active-high and an active-low instance share
// stimulus and are compared every cycle against a frame-level model.
module tb_display7seg_scan;

   localparam int N     = 4;
   localparam int DIV   = 3;
   localparam int FRAME = N * DIV;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   display7seg_scan_if #(.N_DIGITS(N)) bus ();
   display7seg_scan_if #(.N_DIGITS(N)) busInv ();

   assign busInv.load     = bus.load;
   assign busInv.value    = bus.value;
   assign busInv.dp_in    = bus.dp_in;
   assign busInv.blank_lz = bus.blank_lz;

   display7seg_scan #(
      .N_DIGITS(N), .SCAN_DIV(DIV), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   display7seg_scan #(
      .N_DIGITS(N), .SCAN_DIV(DIV), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
   ) dutInv (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (busInv)
   );

   logic [6:0] hexTab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   int checks = 0;
   int errors = 0;

   // Model state: edges since reset release, shown frame, and buffered frame.
   int          t;
   logic [15:0] mAct;
   logic [3:0]  mActDp;
   logic [15:0] mPend;
   logic [3:0]  mPendDp;
   bit          mPendVld;
   logic        blz;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h (t=%0d)", tag, obs, exp, t);
      end
   endtask

   task automatic modelReset();
      t        = 0;
      mAct     = '0;
      mActDp   = '0;
      mPend    = '0;
      mPendDp  = '0;
      mPendVld = 0;
   endtask

   task automatic checkDark();
      chk("dark_seg", 32'(bus.seg), 32'h00);
      chk("dark_dp", 32'(bus.dp), 32'h0);
      chk("dark_an", 32'(bus.an), 32'h0);
      chk("dark_fd", 32'(bus.frame_done), 32'h0);
      chk("dark_seg_inv", 32'(busInv.seg), 32'h7F);
      chk("dark_dp_inv", 32'(busInv.dp), 32'h1);
      chk("dark_an_inv", 32'(busInv.an), 32'hF);
      chk("dark_fd_inv", 32'(busInv.frame_done), 32'h0);
   endtask

   // One clock: drive inputs, predict the pins from the frame the model says
   // is showing, then fold this cycle's load/wrap into the model.
   task automatic applyStimulus(input logic ld, input logic [15:0] v, input logic [3:0] d);
      int         dig;
      logic [15:0] upper;
      logic [6:0] expSeg;
      logic [6:0] expSegInv;
      logic       expDp;
      logic [3:0] expAn;
      logic [3:0] expAnInv;
      logic       expFd;
      bit         wrapNow;
      bus.load     = ld;
      bus.value    = v;
      bus.dp_in    = d;
      bus.blank_lz = blz;
      @(posedge clk);
      t++;
      dig       = ((t - 1) / DIV) % N;
      upper     = mAct >> (4 * dig);
      expSeg    = (blz && dig > 0 && upper == 16'h0) ? 7'h00 : hexTab[upper[3:0]];
      expDp     = mActDp[dig];
      expAn     = 4'(1 << dig);
      expFd     = (t % FRAME == 0);
      expSegInv = ~expSeg;
      expAnInv  = ~expAn;
      wrapNow   = (t % FRAME == 0);
      if (wrapNow) begin
         if (ld) begin
            mAct   = v;
            mActDp = d;
         end else if (mPendVld) begin
            mAct   = mPend;
            mActDp = mPendDp;
         end
      end
      if (ld) begin
         mPend    = v;
         mPendDp  = d;
         mPendVld = !wrapNow;
      end else if (wrapNow) begin
         mPendVld = 0;
      end
      #1;
      checkOutput(expSeg, expDp, expAn, expFd, expSegInv, expAnInv);
      @(negedge clk);
      bus.load = 1'b0;
   endtask

   task automatic checkOutput(input logic [6:0] expSeg, input logic expDp, input logic [3:0] expAn,
                              input logic expFd, input logic [6:0] expSegInv, input logic [3:0] expAnInv);
      chk("seg", 32'(bus.seg), 32'(expSeg));
      chk("dp", 32'(bus.dp), 32'(expDp));
      chk("an", 32'(bus.an), 32'(expAn));
      chk("frame_done", 32'(bus.frame_done), 32'(expFd));
      chk("seg_inv", 32'(busInv.seg), 32'(expSegInv));
      chk("dp_inv", 32'(busInv.dp), 32'(!expDp));
      chk("an_inv", 32'(busInv.an), 32'(expAnInv));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 16'h0, 4'h0);
   endtask

   task automatic idleUntilPhase(input int phase);
      for (int i = 0; i < FRAME && (t % FRAME) != phase; i++) applyStimulus(1'b0, 16'h0, 4'h0);
   endtask

   initial begin
      logic        ld;
      logic [15:0] rv;
      logic [3:0]  rd;

      bus.load     = 1'b0;
      bus.value    = '0;
      bus.dp_in    = '0;
      bus.blank_lz = 1'b0;
      blz          = 1'b0;
      modelReset();

      // Held in reset: everything dark on both polarities.
      repeat (3) @(negedge clk);
      checkDark();
      rst_n = 1'b1;

      // Plain scan of the reset content.
      idle(2 * FRAME);

      // Glyph decode and per-digit decimal point.
      applyStimulus(1'b1, 16'h1A2F, 4'b0100);
      idle(2 * FRAME);

      // Mid-frame load is held back until the next digit 0.
      idleUntilPhase(5);
      applyStimulus(1'b1, 16'h5555, 4'b0000);
      idle(FRAME + 2);

      // Two loads inside one frame: the later one is shown.
      idleUntilPhase(2);
      applyStimulus(1'b1, 16'h1111, 4'b0001);
      idle(3);
      applyStimulus(1'b1, 16'h2222, 4'b1000);
      idle(2 * FRAME);

      // Leading-zero blanking, including the all-zero value.
      blz = 1'b1;
      applyStimulus(1'b1, 16'h0030, 4'b1000);
      idle(2 * FRAME);
      applyStimulus(1'b1, 16'h0000, 4'b0000);
      idle(2 * FRAME);
      blz = 1'b0;

      // Load on the wrap edge goes straight into the next frame.
      idleUntilPhase(FRAME - 1);
      applyStimulus(1'b1, 16'hBEEF, 4'b1010);
      idle(FRAME + 1);

      // Asynchronous reset mid-frame with a load still pending.
      idleUntilPhase(4);
      applyStimulus(1'b1, 16'h9999, 4'b1111);
      idle(2);
      rst_n = 1'b0;
      #1;
      checkDark();
      modelReset();
      @(negedge clk);
      @(negedge clk);
      checkDark();
      rst_n = 1'b1;
      idle(2 * FRAME);

      // Random traffic with occasional blanking toggles.
      for (int i = 0; i < 600; i++) begin
         ld = ($urandom_range(0, 5) == 0);
         rv = 16'($urandom);
         if ($urandom_range(0, 3) == 0) rv[15:8] = 8'h00;
         rd = 4'($urandom);
         if ($urandom_range(0, 39) == 0) blz = ~blz;
         applyStimulus(ld, rv, rd);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
